tt_um_hoene_rgb_frame_receiver: RTL and testbench
=================================================

// Module: tt_um_hoene_rgb_frame_receiver
// PURPOSE
//  Assembles one RGB frame from the Manchester decoder's bit strobes and feeds tt_um_hoene_led_pwm.
//  Sits between tt_um_hoene_manchester_decoder/protocol_insync (upstream) and led_pwm (downstream).
//  Frame = first FRAME_BITS bits after sync, MSB first, order red, green, blue.
//  Bits past the frame are forwarded for the next LED in the chain.
//  Colours are committed on end of burst (insync falling) only if the frame was complete and error-free.
// PARAMETERS
//  COLOR_BITS  10  width of each colour channel; localparam FRAME_BITS = 3*COLOR_BITS (30)
//  CNT_W       5   bit-counter width, must satisfy 2**CNT_W > FRAME_BITS
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  in_data      in   1           decoded bit value, valid when in_clk=1
//  in_clk       in   1           one-cycle bit strobe from the Manchester decoder
//  in_error     in   1           decoder error (pulse width violation), any cycle
//  in_insync    in   1           protocol_insync level; high during a burst
//  data_red     out  COLOR_BITS  committed red value to led_pwm
//  data_green   out  COLOR_BITS  committed green value
//  data_blue    out  COLOR_BITS  committed blue value
//  frame_valid  out  1           one-cycle pulse: new colours committed
//  frame_drop   out  1           one-cycle pulse: burst ended without a valid commit
//  fwd_data     out  1           forwarded bit (bits FRAME_BITS+1 onward)
//  fwd_clk      out  1           one-cycle strobe qualifying fwd_data
// BEHAVIOUR
//  Reset: all outputs 0; shift reg 0; count 0; state IDLE; insync_q 0.
//   Reset mid-frame discards the partial frame and clears the committed colours.
//  FSM states and transitions:
//   IDLE: in_insync=1 goes to RECV with count=0.
//   RECV: each in_clk shifts in_data into shift_reg LSB and increments count.
//    count reaches FRAME_BITS: go to FWD.
//   FWD: each in_clk sets fwd_data<=in_data and fwd_clk<=1 on the next edge (latency 1). count is held.
//   ERR: entered from RECV or FWD when in_error=1. Ignores in_clk; stays until in_insync=0.
//  Burst end: in_insync=0 while insync_q=1.
//   In FWD: data_red=shift_reg[29:20], data_green=[19:10], data_blue=[9:0] on the next edge,
//    with frame_valid=1 for one cycle.
//   In RECV or ERR: colours unchanged, frame_drop=1 for one cycle.
//   Then go to IDLE.
//  Gating and priority:
//   in_clk is ignored when in_insync=0.
//   in_error and in_clk in the same cycle: error wins, the bit is discarded.
//   in_clk and insync falling in the same cycle: the bit is discarded and the burst-end rule applies.
//   in_error in IDLE is ignored.
//  Output timing:
//   frame_valid and frame_drop are never high together.
//   fwd_clk is never high in the same cycle as frame_valid.
//   data_* hold their value between commits; led_pwm may sample them at any time.
//  Widths: count saturates at FRAME_BITS, no wrap. Shift reg is exactly FRAME_BITS wide.
// STRUCTURE
//  Single module, no sub-module. Registers: insync_q, state[1:0], count, shift_reg, data_*, pulses.
//  Shared header tt_um_hoene_defs.vh holds:
//   COLOR_BITS default;
//   FSM state encodings IDLE=0, RECV=1, FWD=2, ERR=3;
//   FRAME_BITS macro, reused by led_pwm and the top-level.
// TESTING
//  1 Burst of 30 bits R=0x3FF G=0x000 B=0x155, then insync low
//    -> frame_valid pulse 1 cycle after insync fall; data_red=0x3FF, data_green=0, data_blue=0x155.
//  2 Burst of 40 bits -> fwd_clk pulses exactly 10 times, each 1 cycle after in_clk, fwd_data matching bits 31..40;
//    colours committed from the first 30.
//  3 Burst of 17 bits, insync falls -> frame_drop pulse; data_* keep previous values.
//  4 in_error at bit 12 of a 30-bit burst -> ERR, later bits ignored, frame_drop at insync fall;
//    error coincident with in_clk -> bit discarded.
//  5 rst_n low at bit 20 (async, mid-cycle) -> all outputs 0 immediately;
//    a following full frame is received normally.
//  6 in_clk in the same cycle as insync falling after 29 bits -> frame_drop; no commit.

Source files
------------

// File: rtl/tt_um_hoene_rgb_frame_receiver_pkg.sv
// tt_um_hoene_rgb_frame_receiver_pkg: shared frame sizing and receiver state encoding
package tt_um_hoene_rgb_frame_receiver_pkg;
    localparam int DEF_COLOR_BITS = 10;
    localparam int DEF_CNT_W = 5;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FWD  = 2'd2,
        ERR  = 2'd3
    } rx_state_t;
endpackage

// File: rtl/tt_um_hoene_rgb_frame_receiver.sv
// tt_um_hoene_rgb_frame_receiver: assembles one RGB frame per burst and forwards surplus bits
module tt_um_hoene_rgb_frame_receiver
    import tt_um_hoene_rgb_frame_receiver_pkg::*;
#(
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_data,
    input  logic                  in_clk,
    input  logic                  in_error,
    input  logic                  in_insync,
    output logic [COLOR_BITS-1:0] data_red,
    output logic [COLOR_BITS-1:0] data_green,
    output logic [COLOR_BITS-1:0] data_blue,
    output logic                  frame_valid,
    output logic                  frame_drop,
    output logic                  fwd_data,
    output logic                  fwd_clk
);
    localparam int FRAME_BITS = 3 * COLOR_BITS;

    rx_state_t state, next_state;
    logic insync_q;
    logic [CNT_W-1:0] count;
    logic [FRAME_BITS-1:0] shift_reg;
    logic burst_end, bit_ok, shift_en, fwd_en, commit, drop;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;

    // Burst end takes priority over error and bit strobes in every active state
    always_comb begin
        next_state = state;
        shift_en = 1'b0;
        fwd_en = 1'b0;
        commit = 1'b0;
        drop = 1'b0;
        burst_end = insync_q & ~in_insync;
        bit_ok = in_clk & in_insync & ~in_error;
        case (state)
            IDLE: next_state = in_insync ? RECV : IDLE;
            RECV: begin
                if (burst_end) begin
                    drop = 1'b1;
                    next_state = IDLE;
                end else if (in_error) next_state = ERR;
                else if (bit_ok) begin
                    shift_en = 1'b1;
                    next_state = (count == CNT_W'(FRAME_BITS - 1)) ? FWD : RECV;
                end
            end
            FWD: begin
                if (burst_end) begin
                    commit = ~in_error;
                    drop = in_error;
                    next_state = IDLE;
                end else if (in_error) next_state = ERR;
                else fwd_en = bit_ok;
            end
            ERR: begin
                drop = burst_end;
                next_state = in_insync ? ERR : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            insync_q <= 1'b0;
            count <= '0;
            shift_reg <= '0;
            data_red <= '0;
            data_green <= '0;
            data_blue <= '0;
            frame_valid <= 1'b0;
            frame_drop <= 1'b0;
            fwd_data <= 1'b0;
            fwd_clk <= 1'b0;
        end else begin
            insync_q <= in_insync;
            frame_valid <= commit;
            frame_drop <= drop;
            fwd_clk <= fwd_en;
            if (fwd_en) fwd_data <= in_data;
            if (state == IDLE) count <= '0;
            else if (shift_en) count <= count + 1'b1;
            if (shift_en) shift_reg <= {shift_reg[FRAME_BITS-2:0], in_data};
            if (commit) begin
                data_red <= shift_reg[FRAME_BITS-1 -: COLOR_BITS];
                data_green <= shift_reg[2*COLOR_BITS-1 -: COLOR_BITS];
                data_blue <= shift_reg[COLOR_BITS-1:0];
            end
        end
endmodule

// File: tb/tb_tt_um_hoene_rgb_frame_receiver.sv
// tb_tt_um_hoene_rgb_frame_receiver: directed, table and random checks against a bit-list model
module tb_tt_um_hoene_rgb_frame_receiver;
    logic clk = 1'b0;
    logic rst_n, in_data, in_clk, in_error, in_insync;
    logic [9:0] data_red, data_green, data_blue;
    logic frame_valid, frame_drop, fwd_data, fwd_clk;

    tt_um_hoene_rgb_frame_receiver dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_clk(in_clk),
        .in_error(in_error), .in_insync(in_insync), .data_red(data_red),
        .data_green(data_green), .data_blue(data_blue), .frame_valid(frame_valid),
        .frame_drop(frame_drop), .fwd_data(fwd_data), .fwd_clk(fwd_clk)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, fwd_seen = 0;

    // Model: list of accepted bits of the current burst plus an error flag
    bit pq, err, m_fv, m_fd, m_fc, m_fwd;
    int n;
    bit mbits[30];
    logic [9:0] m_red, m_green, m_blue;

    typedef struct {
        bit d, c, e, s;
        bit fv, fd, fc;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("frame_drop", 32'(frame_drop), 32'(m_fd));
        chk("fwd_clk", 32'(fwd_clk), 32'(m_fc));
        chk("fwd_data", 32'(fwd_data), 32'(m_fwd));
        chk("data_red", 32'(data_red), 32'(m_red));
        chk("data_green", 32'(data_green), 32'(m_green));
        chk("data_blue", 32'(data_blue), 32'(m_blue));
    endtask

    task automatic cyc(input bit d, input bit c, input bit e, input bit s);
        in_data = d;
        in_clk = c;
        in_error = e;
        in_insync = s;
        m_fv = 0;
        m_fd = 0;
        m_fc = 0;
        if (pq && !s) begin
            if (n == 30 && !err && !e) begin
                m_fv = 1;
                for (int k = 0; k < 10; k++) begin
                    m_red = {m_red[8:0], mbits[k]};
                    m_green = {m_green[8:0], mbits[k+10]};
                    m_blue = {m_blue[8:0], mbits[k+20]};
                end
            end else m_fd = 1;
            n = 0;
            err = 0;
        end else if (pq) begin
            if (e) err = 1;
            else if (c && !err) begin
                if (n < 30) begin
                    mbits[n] = d;
                    n++;
                end else begin
                    m_fc = 1;
                    m_fwd = d;
                end
            end
        end
        pq = s;
        @(posedge clk);
        #1;
        if (fwd_clk) fwd_seen++;
        chk_all();
    endtask

    task automatic model_clear();
        pq = 0; n = 0; err = 0;
        m_fv = 0; m_fd = 0; m_fc = 0; m_fwd = 0;
        m_red = 0; m_green = 0; m_blue = 0;
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk_all();
        in_data = 0; in_clk = 0; in_error = 0; in_insync = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic burst(input logic [63:0] v, input int nb, input int err_at);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < nb; i++) begin
            cyc(v[nb-1-i], 1, i == err_at, 1);
            cyc(0, 0, 0, 1);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    int len;
    bit em;

    initial begin
        rst_n = 1'b0;
        in_data = 0; in_clk = 0; in_error = 0; in_insync = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;

        burst(64'({10'h3FF, 10'h000, 10'h155}), 30, -1);
        chk("t1_red", 32'(data_red), 32'h3FF);
        chk("t1_green", 32'(data_green), 32'h000);
        chk("t1_blue", 32'(data_blue), 32'h155);

        fwd_seen = 0;
        burst(64'({10'h0F0, 10'h30C, 10'h2A5, 10'h1B7}), 40, -1);
        chk("t2_fwd_count", 32'(fwd_seen), 32'd10);
        chk("t2_red", 32'(data_red), 32'h0F0);
        chk("t2_green", 32'(data_green), 32'h30C);
        chk("t2_blue", 32'(data_blue), 32'h2A5);

        burst(64'h1ABCD, 17, -1);
        chk("t3_red_kept", 32'(data_red), 32'h0F0);

        burst(64'({10'h111, 10'h222, 10'h333}), 30, 12);
        chk("t4_blue_kept", 32'(data_blue), 32'h2A5);

        cyc(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(1'(i), 1, 0, 1);
        mid_reset();
        burst(64'({10'h155, 10'h2AA, 10'h3C3}), 30, -1);
        chk("t5_red", 32'(data_red), 32'h155);
        chk("t5_green", 32'(data_green), 32'h2AA);
        chk("t5_blue", 32'(data_blue), 32'h3C3);

        cyc(0, 0, 0, 1);
        for (int i = 0; i < 29; i++) cyc(1'(i + 1), 1, 0, 1);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t6_green_kept", 32'(data_green), 32'h2AA);

        tbl[0] = '{d: 0, c: 0, e: 1, s: 0, fv: 0, fd: 0, fc: 0};
        tbl[1] = '{d: 1, c: 1, e: 0, s: 0, fv: 0, fd: 0, fc: 0};
        tbl[2] = '{d: 0, c: 0, e: 0, s: 1, fv: 0, fd: 0, fc: 0};
        tbl[3] = '{d: 1, c: 1, e: 0, s: 1, fv: 0, fd: 0, fc: 0};
        tbl[4] = '{d: 0, c: 1, e: 1, s: 1, fv: 0, fd: 0, fc: 0};
        tbl[5] = '{d: 0, c: 0, e: 0, s: 1, fv: 0, fd: 0, fc: 0};
        tbl[6] = '{d: 0, c: 0, e: 0, s: 0, fv: 0, fd: 1, fc: 0};
        tbl[7] = '{d: 0, c: 0, e: 0, s: 0, fv: 0, fd: 0, fc: 0};
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].d, tbl[i].c, tbl[i].e, tbl[i].s);
            chk("tbl_valid", 32'(frame_valid), 32'(tbl[i].fv));
            chk("tbl_drop", 32'(frame_drop), 32'(tbl[i].fd));
            chk("tbl_fwd_clk", 32'(fwd_clk), 32'(tbl[i].fc));
        end

        for (int b = 0; b < 40; b++) begin
            len = int'($urandom_range(20, 150));
            em = ($urandom % 4) == 0;
            for (int k = 0; k < len; k++)
                cyc(1'($urandom), ($urandom % 3) == 0, em && (($urandom % 40) == 0), 1);
            cyc(1'($urandom), 1'($urandom), ($urandom % 8) == 0, 0);
            repeat ($urandom_range(1, 3)) cyc(1'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
